// File: rtl/shift_wb_ctrl.sv
// shift_wb_ctrl: write-back path sequencer for the 8-bit processor.
// Sequences the iterative 1-bit-per-cycle shifter and owns the single
// register-file write port.
//
// In IDLE and RUN the ALU has the write port. A shift uses it only
// in its single WB cycle.
//
// Ports:
//   CLK, RESET        clock; synchronous active-high reset
//   ALU_VALID/DEST    single-cycle ALU write request and target register
//   SHIFT_START/AMOUNT/DEST  shift request, step count, target register
//   SHIFT             write-back mux select (0 ALU, 1 shifter)
//   WRITE_ENABLE/ADDRESS     register-file write strobe and address
//   SHIFTER_LOAD/STEP shifter operand load / one 1-bit shift
//   BUSY              issue stall while a shift is in flight
//   DONE              registered pulse the cycle after shift write-back
module shift_wb_ctrl #(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AMT_WIDTH  = 3
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ALU_VALID,
  input  logic [ADDR_WIDTH-1:0] ALU_DEST,
  input  logic                  SHIFT_START,
  input  logic [AMT_WIDTH-1:0]  SHIFT_AMOUNT,
  input  logic [ADDR_WIDTH-1:0] SHIFT_DEST,
  output logic                  SHIFT,
  output logic                  WRITE_ENABLE,
  output logic [ADDR_WIDTH-1:0] WRITE_ADDRESS,
  output logic                  SHIFTER_LOAD,
  output logic                  SHIFTER_STEP,
  output logic                  BUSY,
  output logic                  DONE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [AMT_WIDTH-1:0]  count_q, count_d;
  logic [ADDR_WIDTH-1:0] dest_q,  dest_d;
  logic                  done_q,  done_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      count_q <= '0;
      dest_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dest_q  <= dest_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    dest_d        = dest_q;
    done_d        = 1'b0;
    SHIFT         = 1'b0;
    WRITE_ENABLE  = 1'b0;
    WRITE_ADDRESS = '0;
    SHIFTER_LOAD  = 1'b0;
    SHIFTER_STEP  = 1'b0;
    BUSY          = 1'b0;

    // Under reset every combinational output stays at its zero default.
    if (!RESET) begin
      unique case (state_q)
        IDLE: begin
          WRITE_ENABLE  = ALU_VALID;
          WRITE_ADDRESS = ALU_DEST;
          if (SHIFT_START) begin
            SHIFTER_LOAD = 1'b1;
            dest_d       = SHIFT_DEST;
            if (SHIFT_AMOUNT == '0) begin
              state_d = WB;
            end else begin
              count_d = SHIFT_AMOUNT;
              state_d = RUN;
            end
          end
        end

        RUN: begin
          BUSY          = 1'b1;
          SHIFTER_STEP  = 1'b1;
          WRITE_ENABLE  = ALU_VALID;
          WRITE_ADDRESS = ALU_DEST;
          // RUN is entered only with a non-zero count; the guard keeps the
          // counter from ever wrapping.
          if (count_q != '0) begin
            count_d = count_q - AMT_WIDTH'(1);
          end
          if (count_q <= AMT_WIDTH'(1)) begin
            state_d = WB;
          end
        end

        WB: begin
          BUSY          = 1'b1;
          SHIFT         = 1'b1;
          WRITE_ENABLE  = 1'b1;
          WRITE_ADDRESS = dest_q;
          done_d        = 1'b1;
          state_d       = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign DONE = done_q;

endmodule

// File: tb/tb_shift_wb_ctrl.sv
// Bench for shift_wb_ctrl: directed literal checks followed by randomized
// traffic compared every cycle against a timeline model of shift timing.
module tb_shift_wb_ctrl;

  localparam int unsigned AW = 3;
  localparam int unsigned MW = 3;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          ALU_VALID = 1'b0;
  logic [AW-1:0] ALU_DEST = '0;
  logic          SHIFT_START = 1'b0;
  logic [MW-1:0] SHIFT_AMOUNT = '0;
  logic [AW-1:0] SHIFT_DEST = '0;
  logic          SHIFT, WRITE_ENABLE, SHIFTER_LOAD, SHIFTER_STEP, BUSY, DONE;
  logic [AW-1:0] WRITE_ADDRESS;

  int checks = 0;
  int errors = 0;

  shift_wb_ctrl #(.ADDR_WIDTH(AW), .AMT_WIDTH(MW)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ALU_VALID    (ALU_VALID),
    .ALU_DEST     (ALU_DEST),
    .SHIFT_START  (SHIFT_START),
    .SHIFT_AMOUNT (SHIFT_AMOUNT),
    .SHIFT_DEST   (SHIFT_DEST),
    .SHIFT        (SHIFT),
    .WRITE_ENABLE (WRITE_ENABLE),
    .WRITE_ADDRESS(WRITE_ADDRESS),
    .SHIFTER_LOAD (SHIFTER_LOAD),
    .SHIFTER_STEP (SHIFTER_STEP),
    .BUSY         (BUSY),
    .DONE         (DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then let the
  // combinational outputs settle before any directed check.
  task automatic drive(input logic rst, input logic av, input int ad,
                       input logic ss, input int sa, input int sd);
    @(posedge CLK);
    #1;
    RESET        = rst;
    ALU_VALID    = av;
    ALU_DEST     = AW'(ad);
    SHIFT_START  = ss;
    SHIFT_AMOUNT = MW'(sa);
    SHIFT_DEST   = AW'(sd);
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  // Timeline model: a shift accepted at cycle t0 with amount n is in
  // phase (cyc - t0); phases 1..n step, phase n+1 writes back, and DONE
  // is high in phase n+2.
  bit            cmp_en = 1'b0;
  int            cyc = 0;
  bit            act = 1'b0;
  int            t0 = 0;
  int            n = 0;
  int            dq = 0;
  bit            done_m = 1'b0;
  int            phase;
  bit            wb;
  int            e_shift, e_we, e_wa, e_load, e_step, e_busy;

  always @(negedge CLK) begin
    if (cmp_en) begin
      e_shift = 0; e_we = 0; e_wa = 0; e_load = 0; e_step = 0; e_busy = 0;
      wb = 1'b0;
      if (!RESET) begin
        e_we = int'(ALU_VALID);
        e_wa = int'(ALU_DEST);
        if (act) begin
          phase  = cyc - t0;
          e_busy = 1;
          if (phase <= n) begin
            e_step = 1;
          end else begin
            wb      = 1'b1;
            e_shift = 1;
            e_we    = 1;
            e_wa    = dq;
          end
        end else begin
          e_load = int'(SHIFT_START);
        end
      end
      chk("m_shift", int'(SHIFT), e_shift);
      chk("m_we",    int'(WRITE_ENABLE), e_we);
      chk("m_wa",    int'(WRITE_ADDRESS), e_wa);
      chk("m_load",  int'(SHIFTER_LOAD), e_load);
      chk("m_step",  int'(SHIFTER_STEP), e_step);
      chk("m_busy",  int'(BUSY), e_busy);
      chk("m_done",  int'(DONE), int'(done_m));

      if (RESET) begin
        act    = 1'b0;
        done_m = 1'b0;
      end else begin
        done_m = wb;
        if (wb) begin
          act = 1'b0;
        end else if (!act && SHIFT_START) begin
          act = 1'b1;
          t0  = cyc;
          n   = int'(SHIFT_AMOUNT);
          dq  = int'(SHIFT_DEST);
        end
      end
      cyc++;
    end
  end

  initial begin
    // Reset held with requests active: outputs must all be zero.
    drive(1'b1, 1'b1, 5, 1'b1, 3, 2);
    cmp_en = 1'b1;
    chk("rst_we",   int'(WRITE_ENABLE), 0);
    chk("rst_load", int'(SHIFTER_LOAD), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_wa",   int'(WRITE_ADDRESS), 0);
    idle_cycle();
    chk("post_rst_busy", int'(BUSY), 0);

    // ALU write from IDLE.
    drive(1'b0, 1'b1, 5, 1'b0, 0, 0);
    chk("alu_we",    int'(WRITE_ENABLE), 1);
    chk("alu_wa",    int'(WRITE_ADDRESS), 5);
    chk("alu_shift", int'(SHIFT), 0);
    chk("alu_busy",  int'(BUSY), 0);

    // Shift by 3 to R2.
    drive(1'b0, 1'b0, 0, 1'b1, 3, 2);
    chk("s3_load", int'(SHIFTER_LOAD), 1);
    for (int i = 1; i <= 3; i++) begin
      idle_cycle();
      chk("s3_step", int'(SHIFTER_STEP), 1);
      chk("s3_busy", int'(BUSY), 1);
    end
    idle_cycle();
    chk("s3_wb_shift", int'(SHIFT), 1);
    chk("s3_wb_we",    int'(WRITE_ENABLE), 1);
    chk("s3_wb_wa",    int'(WRITE_ADDRESS), 2);
    idle_cycle();
    chk("s3_done", int'(DONE), 1);
    chk("s3_busy_end", int'(BUSY), 0);

    // Shift by 0 to R7.
    drive(1'b0, 1'b0, 0, 1'b1, 0, 7);
    chk("s0_load", int'(SHIFTER_LOAD), 1);
    idle_cycle();
    chk("s0_shift", int'(SHIFT), 1);
    chk("s0_wa",    int'(WRITE_ADDRESS), 7);
    chk("s0_step",  int'(SHIFTER_STEP), 0);
    idle_cycle();
    chk("s0_done", int'(DONE), 1);

    // Collision and overlap with shift by 2 to R1.
    drive(1'b0, 1'b1, 4, 1'b1, 2, 1);
    chk("col_we",   int'(WRITE_ENABLE), 1);
    chk("col_wa",   int'(WRITE_ADDRESS), 4);
    chk("col_load", int'(SHIFTER_LOAD), 1);
    drive(1'b0, 1'b1, 6, 1'b0, 0, 0);
    chk("run_alu_we",    int'(WRITE_ENABLE), 1);
    chk("run_alu_wa",    int'(WRITE_ADDRESS), 6);
    chk("run_alu_shift", int'(SHIFT), 0);
    drive(1'b0, 1'b0, 0, 1'b1, 5, 3);
    chk("run_ss_load", int'(SHIFTER_LOAD), 0);
    drive(1'b0, 1'b1, 3, 1'b0, 0, 0);
    chk("wb_wa",    int'(WRITE_ADDRESS), 1);
    chk("wb_shift", int'(SHIFT), 1);
    idle_cycle();
    chk("col_done", int'(DONE), 1);
    idle_cycle();
    chk("col_done_once", int'(DONE), 0);

    // Reset during the third step of a shift by 7.
    drive(1'b0, 1'b0, 0, 1'b1, 7, 5);
    idle_cycle();
    idle_cycle();
    drive(1'b1, 1'b0, 0, 1'b0, 0, 0);
    chk("abort_step", int'(SHIFTER_STEP), 0);
    idle_cycle();
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_we",   int'(WRITE_ENABLE), 0);
    chk("abort_done", int'(DONE), 0);
    drive(1'b0, 1'b0, 0, 1'b1, 1, 6);
    idle_cycle();
    chk("s1_step", int'(SHIFTER_STEP), 1);
    idle_cycle();
    chk("s1_wa", int'(WRITE_ADDRESS), 6);
    chk("s1_we", int'(WRITE_ENABLE), 1);

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(49) == 0), $urandom_range(1) == 1,
            int'($urandom_range(7)), $urandom_range(3) == 0,
            int'($urandom_range(7)), int'($urandom_range(7)));
    end
    for (int i = 0; i < 12; i++) idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_wb_ctrl.md
Name: shift_wb_ctrl

Overview:
- Sequencer for the register-file write-back path of the 8-bit processor.
- Sequences an iterative 1-bit-per-cycle shifter and drives the write-back mux select (SHIFT: 0 = ALU result, 1 = shifted value).
- Arbitrates the single register-file write port between single-cycle ALU writes and multi-cycle shift results, and stalls instruction issue while a shift is in flight.

Parameters:
- ADDR_WIDTH, 3, register-file address width (8 registers).
- AMT_WIDTH, 3, shift-amount width (0..7).

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- ALU_VALID  input  1  ALU result on the ALU_RESULT bus is to be written this cycle.
- ALU_DEST  input  ADDR_WIDTH  destination register for the ALU write.
- SHIFT_START  input  1  request to start a shift instruction.
- SHIFT_AMOUNT  input  AMT_WIDTH  number of 1-bit shift steps.
- SHIFT_DEST  input  ADDR_WIDTH  destination register for the shift result.
- SHIFT  output  1  write-back mux select (0 ALU, 1 shifter).
- WRITE_ENABLE  output  1  register-file write strobe.
- WRITE_ADDRESS  output  ADDR_WIDTH  register-file write address.
- SHIFTER_LOAD  output  1  shifter loads its operand this cycle.
- SHIFTER_STEP  output  1  shifter performs one 1-bit shift this cycle.
- BUSY  output  1  stall issue; high whenever state != IDLE.
- DONE  output  1  registered one-cycle pulse, the cycle after the shift write-back.

Behaviour:
- Reset: while RESET=1, at the clock edge state<=IDLE, count<=0, dest_q<=0, DONE<=0.
  - While RESET=1, all combinational outputs are forced to 0 regardless of inputs.
  - Reset mid-shift aborts the shift; no write-back occurs.
- States: IDLE, RUN, WB. Registered state; count (AMT_WIDTH bits); dest_q (ADDR_WIDTH bits).
- IDLE:
  - SHIFT=0; WRITE_ENABLE=ALU_VALID; WRITE_ADDRESS=ALU_DEST.
  - If SHIFT_START=1: SHIFTER_LOAD=1, dest_q<=SHIFT_DEST.
    - SHIFT_AMOUNT=0: next state WB.
    - Otherwise: count<=SHIFT_AMOUNT, next state RUN.
  - SHIFT_START together with ALU_VALID: both are honoured; the ALU write completes this cycle and the shift starts.
- RUN:
  - SHIFTER_STEP=1; count<=count-1.
  - When count==1: next state WB. Exactly SHIFT_AMOUNT STEP cycles occur.
  - ALU_VALID is still honoured in RUN (port is free): WRITE_ENABLE=ALU_VALID, SHIFT=0, WRITE_ADDRESS=ALU_DEST.
- WB:
  - SHIFT=1, WRITE_ENABLE=1, WRITE_ADDRESS=dest_q; next state IDLE; DONE<=1 (DONE high for the following cycle only).
  - ALU_VALID in WB is ignored (shift has priority); upstream must respect BUSY.
- SHIFT_START while state != IDLE is ignored; no queueing.
- Latency:
  - Start cycle (LOAD), then N STEP cycles, then 1 WB cycle.
  - Write-back occurs N+1 cycles after the start cycle (N=0: the very next cycle).
  - BUSY high for N+1 cycles.
- SHIFTER_LOAD and SHIFTER_STEP are never high together; WRITE_ENABLE is never high with SHIFT=1 outside WB.
- Back-to-back: SHIFT_START is accepted in the first IDLE cycle after WB, in the same cycle as DONE=1.
- count never wraps: decrement occurs only in RUN with count>=1.

Test Plan:
- Reset: hold RESET=1 with ALU_VALID=1, SHIFT_START=1 -> all outputs 0; after release, state IDLE, BUSY=0.
- ALU write: IDLE, ALU_VALID=1, ALU_DEST=5 -> same-cycle WRITE_ENABLE=1, WRITE_ADDRESS=5, SHIFT=0, BUSY stays 0.
- Shift by 3 to R2 at cycle t:
  - t: SHIFTER_LOAD=1.
  - t+1..t+3: SHIFTER_STEP=1, BUSY=1.
  - t+4: SHIFT=1, WRITE_ENABLE=1, WRITE_ADDRESS=2.
  - t+5: DONE=1, BUSY=0.
- Shift by 0 to R7 at t -> t+1 write-back with SHIFT=1, address 7; zero STEP cycles; DONE at t+2.
- Collision and overlap:
  - Shift by 2 to R1 with ALU_VALID=1, ALU_DEST=4 at start cycle -> ALU write to R4 at t.
  - ALU_VALID with ALU_DEST=6 during RUN -> write to R6 with SHIFT=0.
  - ALU_VALID during WB -> only the R1 write occurs.
  - SHIFT_START during RUN -> ignored; DONE pulses exactly once.
- Reset mid-shift: shift by 7, assert RESET at the 3rd STEP cycle -> no WB cycle, no DONE, next cycle IDLE; a new shift by 1 then completes in 3 cycles.
